// File: rtl/ysyx_22050019_pkg.sv
// Shared types and constants for the ysyx_22050019 instruction fetch path.
package ysyx_22050019_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } ifetch_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] ARPROT_INST   = 3'b100;

endpackage

// File: rtl/ysyx_22050019_ifetch_axi.sv
// AXI4-Lite read master feeding the IFU: one outstanding fetch, lane select
// from a 64-bit beat, redirect flush that swallows an in-flight beat.
module ysyx_22050019_ifetch_axi
  import ysyx_22050019_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64,
  parameter int INST_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [63:0]           req_addr,
  input  logic                  flush,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_W-1:0]     inst_o,
  output logic [63:0]           inst_addr_o,
  output logic                  inst_err_o,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [2:0]            m_axi_arprot,
  input  logic [AXI_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  ifetch_state_e         state_q, state_d;
  logic [63:0]           pc_q, pc_d;
  logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic [INST_W-1:0]     inst_q, inst_d;
  logic [63:0]           inst_addr_q, inst_addr_d;
  logic                  err_q, err_d;
  logic                  drop_q, drop_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      inst_q      <= '0;
      inst_addr_q <= '0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    err_d       = err_q;
    drop_d      = drop_q;
    req_ready   = 1'b0;

    unique case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_ADDR: begin
        // arvalid may not be withdrawn once raised; remember the flush instead
        if (flush) drop_d = 1'b1;
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (m_axi_rvalid) begin
          drop_d = 1'b0;
          if (drop_q || flush) begin
            state_d = ST_IDLE;
          end else begin
            inst_d      = pc_q[2] ? m_axi_rdata[2*INST_W-1:INST_W] : m_axi_rdata[INST_W-1:0];
            inst_addr_d = pc_q;
            err_d       = (m_axi_rresp != AXI_RESP_OKAY);
            state_d     = ST_HOLD;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        req_ready = inst_ready || flush;
        if (req_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new request overrides whatever the state logic chose, including flush.
    if (req_valid && req_ready) begin
      pc_d   = req_addr;
      drop_d = 1'b0;
      if (req_addr[1:0] != 2'b00) begin
        state_d     = ST_HOLD;
        inst_d      = '0;
        inst_addr_d = req_addr;
        err_d       = 1'b1;
      end else begin
        state_d   = ST_ADDR;
        araddr_d  = {req_addr[AXI_ADDR_W-1:3], 3'b000};
        arvalid_d = 1'b1;
      end
    end
  end

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_arprot  = ARPROT_INST;
  assign m_axi_rready  = (state_q == ST_DATA);
  assign inst_valid    = (state_q == ST_HOLD);
  assign inst_o        = inst_q;
  assign inst_addr_o   = inst_addr_q;
  assign inst_err_o    = err_q;

endmodule

// File: tb/tb_ysyx_22050019_ifetch_axi.sv
// Bench for the instruction fetch AXI master: scripted AXI slave, scoreboard
// of expected instructions, a vector table and hand-built corner sequences.
module tb_ysyx_22050019_ifetch_axi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, flush;
  logic [63:0] req_addr;
  logic        inst_valid, inst_ready, inst_err_o;
  logic [31:0] inst_o;
  logic [63:0] inst_addr_o;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [2:0]  m_axi_arprot;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  ysyx_22050019_ifetch_axi dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .flush(flush),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_o(inst_o),
    .inst_addr_o(inst_addr_o), .inst_err_o(inst_err_o),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_arprot(m_axi_arprot), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] addr;
    logic        err;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    int          ar_dly;
    int          r_dly;
    logic [1:0]  resp;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  int checks = 0, errors = 0;
  int slv_st = 0, slv_ar_dly = 0, slv_r_dly = 0;
  logic [1:0] slv_resp = 2'b00;
  int ar_hs = 0, r_done = 0, iv_cycles = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory image: low word = araddr^0xBEEF, high word = araddr^0xDEAD0000,
  // except the line at 0x8000_0000 which holds two real RV instructions.
  function automatic logic [63:0] mem_line(input logic [31:0] a);
    if (a == 32'h8000_0000) return 64'h0010_0093_0000_0013;
    return {a ^ 32'hDEAD_0000, a ^ 32'h0000_BEEF};
  endfunction

  // AXI slave: delays and response taken from slv_* at the time of use.
  initial begin
    int cnt;
    logic [31:0] cap;
    cnt = 0; cap = '0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        slv_st = 0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      end else begin
        case (slv_st)
          0: if (m_axi_arvalid) begin
            cap = m_axi_araddr;
            if (slv_ar_dly == 0) begin m_axi_arready = 1'b1; slv_st = 2; end
            else begin cnt = slv_ar_dly; slv_st = 1; end
          end
          1: begin
            chk("arvalid_held", {63'd0, m_axi_arvalid}, 64'd1);
            chk("araddr_stable", {32'd0, m_axi_araddr}, {32'd0, cap});
            cnt--;
            if (cnt == 0) begin m_axi_arready = 1'b1; slv_st = 2; end
          end
          2: begin
            m_axi_arready = 1'b0;
            ar_hs++;
            m_axi_rdata = mem_line(cap);
            m_axi_rresp = slv_resp;
            if (slv_r_dly == 0) begin m_axi_rvalid = 1'b1; slv_st = 3; end
            else begin cnt = slv_r_dly; slv_st = 4; end
          end
          4: begin
            cnt--;
            if (cnt == 0) begin m_axi_rvalid = 1'b1; slv_st = 3; end
          end
          3: begin m_axi_rvalid = 1'b0; r_done++; slv_st = 0; end
          default: slv_st = 0;
        endcase
      end
    end
  end

  // Consumer side: every delivered instruction must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && inst_valid) begin
        iv_cycles++;
        if (inst_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_inst", {32'd0, inst_o}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("inst_o", {32'd0, inst_o}, {32'd0, e.inst});
            chk("inst_addr_o", inst_addr_o, e.addr);
            chk("inst_err_o", {63'd0, inst_err_o}, {63'd0, e.err});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic [63:0] a, input bit push, input exp_t e);
    int n;
    n = 0;
    req_addr = a; req_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    chk("req_accept", {63'd0, req_ready}, 64'd1);
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(sb.size() == 0 && !inst_valid && !m_axi_arvalid && !m_axi_rready && slv_st == 0) && n < 200);
    chk("drain_done", {63'd0, n < 200}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_sig(input string nm, input bit which_iv);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(which_iv ? inst_valid : m_axi_rready) && n < 50);
    chk(nm, {63'd0, n < 50}, 64'd1);
  endtask

  vec_t vt[6];
  exp_t e;

  initial begin
    int hs0, rd0, iv0;
    vt[0] = '{64'h0000_0000_8000_0004, 0, 0, 2'b00, 32'h0010_0093, 1'b0};
    vt[1] = '{64'h0000_0000_8000_0000, 0, 0, 2'b10, 32'h0000_0013, 1'b1};
    vt[2] = '{64'h0000_0000_8000_0002, 0, 0, 2'b00, 32'h0000_0000, 1'b1};
    vt[3] = '{64'h0000_0000_8000_0008, 2, 3, 2'b00, 32'h8000_BEE7, 1'b0};
    vt[4] = '{64'h0000_0001_1000_0014, 1, 0, 2'b00, 32'hCEAD_0010, 1'b0};
    vt[5] = '{64'h0000_0000_1000_0010, 0, 2, 2'b11, 32'h1000_BEFF, 1'b1};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; inst_ready = 1'b1;
    #2;
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
    chk("rst_araddr", {32'd0, m_axi_araddr}, 64'd0);
    chk("rst_inst_o", {32'd0, inst_o}, 64'd0);
    chk("rst_inst_addr", inst_addr_o, 64'd0);
    chk("rst_err", {63'd0, inst_err_o}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("arprot", {61'd0, m_axi_arprot}, 64'd4);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: accept cycle 0, arvalid cycle 1, rready cycle 2, inst_valid cycle 3.
    req_addr = 64'h8000_0004; req_valid = 1'b1;
    sb.push_back('{32'h0010_0093, 64'h8000_0004, 1'b0});
    @(negedge clk); chk("lat_req_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    chk("lat_arvalid_c1", {63'd0, m_axi_arvalid}, 64'd1);
    chk("lat_araddr", {32'd0, m_axi_araddr}, 64'h8000_0000);
    @(negedge clk);
    chk("lat_rready_c2", {63'd0, m_axi_rready}, 64'd1);
    chk("lat_arvalid_c2", {63'd0, m_axi_arvalid}, 64'd0);
    @(negedge clk);
    chk("lat_inst_valid_c3", {63'd0, inst_valid}, 64'd1);
    drain();

    // Backpressure, then back-to-back accept on release.
    inst_ready = 1'b0;
    do_req(64'h8000_0004, 1'b1, '{32'h0010_0093, 64'h8000_0004, 1'b0});
    wait_sig("bp_wait_iv", 1'b1);
    req_addr = 64'h8000_0008; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_inst_valid", {63'd0, inst_valid}, 64'd1);
      chk("bp_inst_o", {32'd0, inst_o}, 64'h0010_0093);
      chk("bp_inst_addr", inst_addr_o, 64'h8000_0004);
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
    end
    @(posedge clk); #1; inst_ready = 1'b1;
    do_req(64'h8000_0008, 1'b1, '{32'h8000_BEE7, 64'h8000_0008, 1'b0});
    @(negedge clk);
    chk("b2b_arvalid", {63'd0, m_axi_arvalid}, 64'd1);
    chk("b2b_araddr", {32'd0, m_axi_araddr}, 64'h8000_0008);
    drain();

    // Flush while in ADDR with a slow arready: beat swallowed, nothing delivered.
    slv_ar_dly = 4; slv_r_dly = 0; slv_resp = 2'b00;
    rd0 = r_done; iv0 = iv_cycles;
    do_req(64'h8000_0010, 1'b0, e);
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    drain();
    chk("flush_addr_beat_taken", r_done - rd0, 1);
    chk("flush_addr_no_inst", iv_cycles - iv0, 0);

    // Flush while in DATA before rvalid.
    slv_ar_dly = 0; slv_r_dly = 3;
    rd0 = r_done; iv0 = iv_cycles;
    do_req(64'h8000_0018, 1'b0, e);
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    drain();
    chk("flush_data_beat_taken", r_done - rd0, 1);
    chk("flush_data_no_inst", iv_cycles - iv0, 0);

    // Flush together with a new request in IDLE keeps the new request.
    slv_r_dly = 0;
    flush = 1'b1;
    do_req(64'h8000_0004, 1'b1, '{32'h0010_0093, 64'h8000_0004, 1'b0});
    flush = 1'b0;
    drain();

    // Flush in HOLD with a new request: old instruction dropped, new one kept.
    inst_ready = 1'b0;
    do_req(64'h8000_0000, 1'b0, e);
    wait_sig("hold_wait_iv", 1'b1);
    @(posedge clk); #1;
    flush = 1'b1;
    do_req(64'h8000_0008, 1'b1, '{32'h8000_BEE7, 64'h8000_0008, 1'b0});
    flush = 1'b0; inst_ready = 1'b1;
    drain();

    // Vector table.
    foreach (vt[i]) begin
      slv_ar_dly = vt[i].ar_dly; slv_r_dly = vt[i].r_dly; slv_resp = vt[i].resp;
      hs0 = ar_hs;
      do_req(vt[i].addr, 1'b1, '{vt[i].exp_inst, vt[i].addr, vt[i].exp_err});
      drain();
      chk("vec_bus_access", ar_hs - hs0, (vt[i].addr[1:0] != 2'b00) ? 0 : 1);
    end

    // Asynchronous reset while waiting in DATA.
    slv_ar_dly = 0; slv_r_dly = 5; slv_resp = 2'b00;
    do_req(64'h8000_0008, 1'b0, e);
    wait_sig("rst_wait_rready", 1'b0);
    #3; rst_n = 1'b0; #1;
    chk("arst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("arst_rready", {63'd0, m_axi_rready}, 64'd0);
    chk("arst_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
    chk("arst_inst_o", {32'd0, inst_o}, 64'd0);
    chk("arst_inst_addr", inst_addr_o, 64'd0);
    chk("arst_err", {63'd0, inst_err_o}, 64'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_req_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    slv_r_dly = 0;
    do_req(64'h8000_0004, 1'b1, '{32'h0010_0093, 64'h8000_0004, 1'b0});
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050019_ifetch_axi.md
Name: ysyx_22050019_ifetch_axi

Overview:
AXI4-Lite read master that fetches 32-bit instructions for the IFU.
- Upstream of the IFU pipeline register: takes the fetch PC via a valid/ready request port, issues one AR/R transaction, selects the 32-bit lane, and presents instruction plus PC to the IFU with valid/ready.
- Supports redirect flush of an in-flight fetch.
- One outstanding transaction at a time.

Parameters:
AXI_ADDR_W, 32, AXI address width; low bits of the 64-bit PC.
AXI_DATA_W, 64, AXI read data width; two instruction lanes per beat.
INST_W, 32, instruction width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  fetch request from PC logic
req_ready  out  1  request accepted when req_valid && req_ready
req_addr  in  64  fetch PC
flush  in  1  redirect; discard any accepted, undelivered fetch
inst_valid  out  1  instruction available
inst_ready  in  1  IFU consumes when inst_valid && inst_ready
inst_o  out  32  fetched instruction
inst_addr_o  out  64  PC of inst_o
inst_err_o  out  1  bus error or misaligned PC
m_axi_araddr  out  32  read address, 8-byte aligned
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_arprot  out  3  constant 3'b100 (instruction access)
m_axi_rdata  in  64  read data
m_axi_rresp  in  2  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE.
  - arvalid=0, araddr=0, inst_o=0, inst_addr_o=0, inst_err_o=0, inst_valid=0, drop flag=0.
  - Reset mid-transaction abandons it; the AXI slave shares the reset, so no stale R beat is expected.
- States: IDLE, ADDR, DATA, HOLD.
- IDLE:
  - req_ready=1.
  - On accept, latch req_addr.
  - If req_addr[1:0]!=0, go to HOLD with inst_o=0 and inst_err_o=1; no bus access.
  - Otherwise go to ADDR, registering araddr={req_addr[31:3],3'b000} and arvalid=1.
- ADDR:
  - arvalid=1; araddr stable until the handshake.
  - On arready go to DATA, with arvalid=0 next cycle.
  - flush here must not drop arvalid (AXI rule); it sets the drop flag instead.
- DATA:
  - rready=1.
  - On rvalid, if the drop flag is set or flush is high this cycle: discard the beat, clear the flag, go to IDLE.
  - Otherwise latch inst_o = rdata[63:32] if addr[2] else rdata[31:0], inst_addr_o = latched PC, inst_err_o = (rresp!=2'b00). Go to HOLD.
  - flush without rvalid sets the drop flag.
- HOLD:
  - inst_valid=1; outputs stable until consumed.
  - Consumed on inst_ready, or discarded on flush.
  - req_ready = inst_ready || flush, so a new request can be accepted in the same cycle (back-to-back), with the IDLE rules applied to it. Without a new request, go to IDLE.
- Latency: accept at cycle 0 → arvalid at cycle 1. With arready at 1 and rvalid at 2, inst_valid is at cycle 3. Sustained throughput is one instruction per 3 cycles at zero wait states.
- flush in IDLE has no effect.
- flush together with a new request (IDLE, or HOLD with req_ready=1) keeps the new request; flush applies only to fetches accepted earlier.
- The drop flag never survives into a new request.
- rvalid in IDLE/ADDR/HOLD is a protocol violation: rready=0, ignored.
- rready and inst_valid decode from the state register; arvalid and araddr are registers.

Decomposition:
- Shared package ysyx_22050019_pkg holds:
  - state enum (IDLE/ADDR/DATA/HOLD)
  - AXI_RESP_OKAY=2'b00
  - ARPROT_INST=3'b100
- Single module; lane select and FSM are small enough that no sub-module is warranted.

Test Plan:
- Aligned fetch: req_addr=0x8000_0004, arready at cycle 1, rvalid at cycle 2 with rdata=0x0010_0093_0000_0013 → cycle 3: inst_valid=1, inst_o=0x0010_0093, inst_addr_o=0x8000_0004, araddr was 0x8000_0000, err=0.
- Backpressure: inst_ready=0 for 5 cycles → inst_o, inst_addr_o and inst_valid held; req_ready=0. When inst_ready=1 with req_valid=1 and addr 0x8000_0008 → accepted the same cycle, arvalid the next cycle.
- Flush in ADDR with arready delayed 4 cycles → arvalid stays 1 and araddr stable; R beat consumed (rready=1), inst_valid never asserts, FSM returns to IDLE.
- Bus error: rresp=2'b10 on fetch of 0x8000_0000 → inst_valid=1, inst_err_o=1, inst_addr_o=0x8000_0000.
- Misaligned req_addr=0x8000_0002 → no arvalid ever; next cycle inst_valid=1, inst_err_o=1, inst_o=0.
- Async reset asserted in DATA → outputs 0 immediately without a clock; after release, req_ready=1 and a fresh fetch completes normally.
